// File: rtl/audio_tdm_tx_driver.sv
// I2S/TDM serial DAC transmitter with a one-frame handshaked buffer, running on the falling edge of the codec bit clock.
// Define AUD_TX_UNDERRUN_CNT_EN to add the saturating o_underrun_cnt output.
module audio_tdm_tx_driver #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int SLOT_WIDTH    = 32,
  parameter int NUM_CH        = 2,
  parameter int DATA_DELAY    = 1,
  parameter int FS_EDGE       = 0
) (
  input  logic                            iAUDB_CLK,
  input  logic                            reset_reg_N,
  input  logic                            iAUD_DACLRCK,
  input  logic                            i2s_enable,
  input  logic [NUM_CH*AUD_BIT_DEPTH-1:0] i_sample_data,
  input  logic                            i_sample_valid,
  output logic                            o_sample_ready,
  output logic                            oAUD_DACDAT,
  output logic                            o_underrun,
  output logic                            o_sync_err
`ifdef AUD_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                     o_underrun_cnt
`endif
);

  localparam int FRAME_BITS = NUM_CH * SLOT_WIDTH;
  localparam int DATA_W     = NUM_CH * AUD_BIT_DEPTH;
  localparam int MAX_CNT    = FRAME_BITS + DATA_DELAY;
  localparam int CNT_W      = $clog2(MAX_CNT + 2);
  localparam int POS_W      = CNT_W + 1;
  localparam bit HALF_CHECK = (NUM_CH == 2) && (FS_EDGE == 0);

  logic                  lrck_dly;
  logic                  en_s1;
  logic                  en_s2;
  logic                  en_active;
  logic                  seen_frame;
  logic                  buf_full;
  logic [DATA_W-1:0]     buf_data;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      count;

  logic                  rise;
  logic                  fall;
  logic                  frame_edge;
  logic                  opp_edge;
  logic                  accept;
  logic [CNT_W-1:0]      count_inc;
  logic [CNT_W-1:0]      next_count;
  logic signed [POS_W-1:0] pos;
  logic                  consume;
  logic                  en_active_next;
  logic                  underrun_next;
  logic                  sync_err_next;
  logic [DATA_W-1:0]     load_data;
  logic [FRAME_BITS-1:0] shift_pre;

  // Lay the frame out in wire order (ch0 MSB first, pad bits after each sample) so the
  // serialiser only ever shifts out the top bit.
  function automatic logic [FRAME_BITS-1:0] format_frame(input logic [DATA_W-1:0] d);
    logic [FRAME_BITS-1:0] f;
    f = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int b = 0; b < AUD_BIT_DEPTH; b++) begin
        f[FRAME_BITS-1-c*SLOT_WIDTH-b] = d[c*AUD_BIT_DEPTH+AUD_BIT_DEPTH-1-b];
      end
    end
    return f;
  endfunction

  assign rise           = iAUD_DACLRCK & ~lrck_dly;
  assign fall           = ~iAUD_DACLRCK & lrck_dly;
  assign frame_edge     = (FS_EDGE != 0) ? rise : fall;
  assign opp_edge       = (FS_EDGE != 0) ? fall : rise;
  assign accept         = i_sample_valid & ~buf_full;
  assign o_sample_ready = ~buf_full;
  assign count_inc      = count + CNT_W'(1);

  always_comb begin
    // NOTE: every output of this block is given a default first, so no path infers a latch.
    load_data  = '0;
    shift_pre  = shift_reg;
    next_count = (count == CNT_W'(MAX_CNT)) ? count : count_inc;
    if (buf_full) begin
      load_data = buf_data;
    end else if (i_sample_valid) begin
      load_data = i_sample_data;
    end
    if (frame_edge) begin
      shift_pre  = format_frame(load_data);
      next_count = '0;
    end
    // pos is the wire bit index this edge drives; negative during the data-delay gap.
    pos            = $signed({1'b0, next_count}) - $signed(POS_W'(DATA_DELAY));
    consume        = (pos >= 0) && (pos < $signed(POS_W'(FRAME_BITS)));
    en_active_next = en_s2 & (frame_edge | en_active);
    underrun_next  = frame_edge & ~buf_full & ~i_sample_valid;
    sync_err_next  = seen_frame &
                     ((frame_edge & (count_inc != CNT_W'(FRAME_BITS))) |
                      (HALF_CHECK & opp_edge & (count_inc != CNT_W'(SLOT_WIDTH))));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(negedge iAUDB_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      lrck_dly    <= 1'b0;
      en_s1       <= 1'b0;
      en_s2       <= 1'b0;
      en_active   <= 1'b0;
      seen_frame  <= 1'b0;
      buf_full    <= 1'b0;
      shift_reg   <= '0;
      count       <= '0;
      oAUD_DACDAT <= 1'b0;
      o_underrun  <= 1'b0;
      o_sync_err  <= 1'b0;
    end else begin
      lrck_dly    <= iAUD_DACLRCK;
      en_s1       <= i2s_enable;
      en_s2       <= en_s1;
      en_active   <= en_active_next;
      count       <= next_count;
      shift_reg   <= consume ? {shift_pre[FRAME_BITS-2:0], 1'b0} : shift_pre;
      oAUD_DACDAT <= en_active_next & consume & shift_pre[FRAME_BITS-1];
      o_underrun  <= underrun_next;
      o_sync_err  <= sync_err_next;
      if (frame_edge) begin
        seen_frame <= 1'b1;
        buf_full   <= 1'b0;
      end else if (accept) begin
        buf_full <= 1'b1;
      end
    end
  end

  // NOTE: the payload register has no reset; buf_full alone says whether it holds a frame.
  always_ff @(negedge iAUDB_CLK) begin
    if (accept && !frame_edge) begin
      buf_data <= i_sample_data;
    end
  end

`ifdef AUD_TX_UNDERRUN_CNT_EN
  always_ff @(negedge iAUDB_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      o_underrun_cnt <= '0;
    end else if (underrun_next && (o_underrun_cnt != 16'hFFFF)) begin
      o_underrun_cnt <= o_underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_tdm_tx_driver.sv
// Directed bench: stereo I2S instance (defaults) and an 8-channel TDM instance with
// DATA_DELAY=0 and rising-edge pulse sync, sharing clock, reset and enable.
module tb_audio_tdm_tx_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         en;
  logic         lrck_a, valid_a, ready_a, dat_a, urun_a, serr_a;
  logic [47:0]  data_a;
  logic         lrck_b, valid_b, ready_b, dat_b, urun_b, serr_b;
  logic [191:0] data_b;
`ifdef AUD_TX_UNDERRUN_CNT_EN
  logic [15:0]  ucnt_a, ucnt_b;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  audio_tdm_tx_driver dut_a (
    .iAUDB_CLK(clk), .reset_reg_N(rst_n), .iAUD_DACLRCK(lrck_a), .i2s_enable(en),
    .i_sample_data(data_a), .i_sample_valid(valid_a), .o_sample_ready(ready_a),
    .oAUD_DACDAT(dat_a), .o_underrun(urun_a), .o_sync_err(serr_a)
`ifdef AUD_TX_UNDERRUN_CNT_EN
    , .o_underrun_cnt(ucnt_a)
`endif
  );

  audio_tdm_tx_driver #(
    .AUD_BIT_DEPTH(24), .SLOT_WIDTH(32), .NUM_CH(8), .DATA_DELAY(0), .FS_EDGE(1)
  ) dut_b (
    .iAUDB_CLK(clk), .reset_reg_N(rst_n), .iAUD_DACLRCK(lrck_b), .i2s_enable(en),
    .i_sample_data(data_b), .i_sample_valid(valid_b), .o_sample_ready(ready_b),
    .oAUD_DACDAT(dat_b), .o_underrun(urun_b), .o_sync_err(serr_b)
`ifdef AUD_TX_UNDERRUN_CNT_EN
    , .o_underrun_cnt(ucnt_b)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs change on the falling edge; look at them 1 time unit later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Wire bit p of a stereo 24-in-32 frame.
  function automatic logic bit_a(input logic [47:0] d, input int p);
    logic r;
    r = 1'b0;
    if (p >= 0 && p < 64 && (p % 32) < 24) r = d[(p / 32) * 24 + 23 - (p % 32)];
    return r;
  endfunction

  // Wire bit p of an 8-slot 24-in-32 frame.
  function automatic logic bit_b(input logic [191:0] d, input int p);
    logic r;
    r = 1'b0;
    if (p >= 0 && p < 256 && (p % 32) < 24) r = d[(p / 32) * 24 + 23 - (p % 32)];
    return r;
  endfunction

  function automatic logic [191:0] mk_b(input int f);
    logic [191:0] d;
    for (int n = 0; n < 8; n++) d[n*24 +: 24] = 24'(n << 20) | 24'(f * 16 + n + 1);
    return d;
  endfunction

  // One stereo frame of len bclks (LRCK low for the first 32). gate: bits from gate on are
  // expected silent, with the 4 bits after a mid-frame enable drop left unchecked.
  task automatic frame_a(input int f, input int len, input bit given, input logic [47:0] cur,
                         input bit feed, input logic [47:0] nxt, input int exp_serr,
                         input int gate, input int en_off, input int en_on,
                         output logic [63:0] got);
    logic [63:0] exp_v, mask;
    int urun_n, serr_n, rdy_low;
    bit take;
    got = '0; exp_v = '0; mask = '0; urun_n = 0; serr_n = 0; rdy_low = 0;
    for (int k = 0; k < len; k++) begin
      lrck_a = (k >= 32);
      if (k == en_off) en = 1'b0;
      if (k == en_on) en = 1'b1;
      if (feed && k == 1) begin
        valid_a = 1'b1;
        data_a  = nxt;
      end
      take = valid_a && ready_a;
      step();
      if (take) valid_a = 1'b0;
      got[k] = dat_a;
      urun_n += int'(urun_a);
      serr_n += int'(serr_a);
      if (!ready_a) rdy_low++;
      if (k < gate) begin
        mask[k]  = 1'b1;
        exp_v[k] = bit_a(cur, k - 1);
      end else if (gate == 0 || k >= gate + 4) begin
        mask[k] = 1'b1;
      end
    end
    check($sformatf("a_f%0d_serial", f), got & mask, exp_v);
    check($sformatf("a_f%0d_underrun", f), urun_n, given ? 0 : 1);
    check($sformatf("a_f%0d_sync_err", f), serr_n, exp_serr);
    if (feed) check($sformatf("a_f%0d_ready_end", f), ready_a, 0);
    else      check($sformatf("a_f%0d_ready_low", f), rdy_low, 0);
  endtask

  task automatic frame_b(input int f, input logic [191:0] cur, input bit feed,
                         input logic [191:0] nxt, output logic [255:0] got);
    logic [255:0] exp_v;
    int urun_n, serr_n;
    bit take;
    got = '0; exp_v = '0; urun_n = 0; serr_n = 0;
    for (int k = 0; k < 256; k++) begin
      lrck_b = (k == 0);
      if (feed && k == 1) begin
        valid_b = 1'b1;
        data_b  = nxt;
      end
      take = valid_b && ready_b;
      step();
      if (take) valid_b = 1'b0;
      got[k]   = dat_b;
      exp_v[k] = bit_b(cur, k);
      urun_n += int'(urun_b);
      serr_n += int'(serr_b);
    end
    check($sformatf("b_f%0d_serial", f), got, exp_v);
    check($sformatf("b_f%0d_underrun", f), urun_n, 0);
    check($sformatf("b_f%0d_sync_err", f), serr_n, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [47:0]  d [10];
    logic [63:0]  ga;
    logic [255:0] gb;
    logic [23:0]  w;
    logic [3:0]   nib;
    int           post_ones;
    bit           take;

    d[0] = {24'h7FFFFE, 24'h800001};
    d[1] = 48'h0;
    d[2] = {24'hA5A5A5, 24'h5A5A5A};
    d[3] = {24'hFFF000, 24'h000FFF};
    d[4] = {24'h800000, 24'h7FFFFF};
    d[5] = {24'h123456, 24'h654321};
    d[6] = {24'hFFFFFF, 24'hFFFFFF};
    d[7] = {24'h0F0F0F, 24'hC00003};
    d[8] = {24'hFFFFFF, 24'h3C3C3C};
    d[9] = {24'h111111, 24'h222222};

    rst_n = 1'b1; en = 1'b1; lrck_a = 1'b1; lrck_b = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0; data_a = '0; data_b = '0;
    #1 rst_n = 1'b0;
    #1;
    check("a_rst_dat", dat_a, 0);
    check("a_rst_ready", ready_a, 1);
    check("a_rst_underrun", urun_a, 0);
    check("a_rst_sync_err", serr_a, 0);
    check("b_rst_ready", ready_b, 1);
    step();
    step();
    rst_n = 1'b1;

    // Preload frame 0 while LRCK idles high.
    valid_a = 1'b1;
    data_a  = d[0];
    for (int i = 0; i < 8; i++) begin
      take = valid_a && ready_a;
      step();
      if (take) valid_a = 1'b0;
    end

    frame_a(0, 64, 1, d[0], 0, '0,   0, 64, -1, -1, ga);
    for (int i = 0; i < 24; i++) w[23-i] = ga[1+i];
    check("a_f0_ch0_word", w, 24'h800001);
    for (int i = 0; i < 24; i++) w[23-i] = ga[33+i];
    check("a_f0_ch1_word", w, 24'h7FFFFE);
    check("a_f0_pad", ga[32:25], 8'h00);
    frame_a(1, 64, 0, d[1], 1, d[2], 0, 64, -1, -1, ga);
    frame_a(2, 64, 1, d[2], 1, d[3], 0, 64, -1, -1, ga);
    frame_a(3, 61, 1, d[3], 1, d[4], 0, 61, -1, -1, ga);
    frame_a(4, 64, 1, d[4], 1, d[5], 1, 64, -1, -1, ga);
    frame_a(5, 64, 1, d[5], 1, d[6], 0, 10, 10, -1, ga);
    frame_a(6, 64, 1, d[6], 1, d[7], 0, 0,  -1, 20, ga);
    frame_a(7, 64, 1, d[7], 1, d[8], 0, 64, -1, -1, ga);

    // Frame 8: reset hits in the middle of slot 1 while the next frame is buffered.
    post_ones = 0;
    for (int k = 0; k < 64; k++) begin
      lrck_a = (k >= 32);
      if (k == 1) begin
        valid_a = 1'b1;
        data_a  = d[9];
      end
      take = valid_a && ready_a;
      step();
      if (take) valid_a = 1'b0;
      if (k > 40) post_ones += int'(dat_a);
      if (k == 40) begin
        check("a_f8_pre_rst_dat", dat_a, 1);
        check("a_f8_pre_rst_ready", ready_a, 0);
        rst_n   = 1'b0;
        valid_a = 1'b0;
        #1;
        check("a_mid_rst_dat", dat_a, 0);
        check("a_mid_rst_ready", ready_a, 1);
        check("a_mid_rst_underrun", urun_a, 0);
        check("a_mid_rst_sync_err", serr_a, 0);
      end
      if (k == 43) rst_n = 1'b1;
    end
    check("a_post_rst_silent", post_ones, 0);
    frame_a(9, 64, 0, d[1], 0, '0, 0, 64, -1, -1, ga);

    // TDM instance: preload frame 0, then four pulse-synced frames.
    valid_b = 1'b1;
    data_b  = mk_b(0);
    for (int i = 0; i < 4; i++) begin
      take = valid_b && ready_b;
      step();
      if (take) valid_b = 1'b0;
    end
    for (int f = 0; f < 4; f++) begin
      frame_b(f, mk_b(f), f < 3, mk_b(f + 1), gb);
      if (f == 0) begin
        for (int n = 0; n < 8; n++) begin
          nib = {gb[32*n], gb[32*n+1], gb[32*n+2], gb[32*n+3]};
          check($sformatf("b_slot%0d_msbs", n), nib, 4'(n));
        end
      end
    end

`ifdef AUD_TX_UNDERRUN_CNT_EN
    check("a_underrun_cnt", ucnt_a, 16'd1);
    check("b_underrun_cnt", ucnt_b, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
